// File: rtl/op_share_sched_if.sv
// Requester/consumer bundle for op_share_sched.
// rsp_carry exists only when OP_SHARE_SCHED_CARRY_EN is defined.
interface op_share_sched_if #(
  parameter int WIDTH = 1,
  parameter int NREQ  = 3,
  parameter int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
`ifdef OP_SHARE_SCHED_CARRY_EN
  logic                  rsp_carry;
`endif

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
`ifdef OP_SHARE_SCHED_CARRY_EN
    , output rsp_carry
`endif
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
`ifdef OP_SHARE_SCHED_CARRY_EN
    , input rsp_carry
`endif
  );
endinterface

// File: rtl/op_share_sched.sv
// Round-robin scheduler sharing one registered add/reg/sub/xor unit among NREQ requesters.
// Optional carry/borrow output enabled by OP_SHARE_SCHED_CARRY_EN.
module op_share_sched #(
  parameter int WIDTH = 1,
  parameter int NREQ  = 3
) (
  input logic           CLK,
  input logic           RST,
  op_share_sched_if.slave bus
);
  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
`ifdef OP_SHARE_SCHED_CARRY_EN
  logic             carry_q, carry_d;
  logic             carry_res;
`endif

  logic             found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic             can_issue;
  logic             transfer;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [1:0]       opc;

  // First valid requester at or after ptr, wrapping past NREQ-1.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign can_issue = (state_q == EMPTY) | ((state_q == FULL) & bus.rsp_ready);
  // Reset blocks handshakes so nothing is accepted in a reset cycle.
  assign transfer  = can_issue & found & ~RST;

  assign bus.req_ready = transfer ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
`ifdef OP_SHARE_SCHED_CARRY_EN
  assign bus.rsp_carry = carry_q;
`endif

  assign op_a = bus.req_a[32'(gnt_idx)*WIDTH +: WIDTH];
  assign op_b = bus.req_b[32'(gnt_idx)*WIDTH +: WIDTH];
  assign opc  = bus.req_op[32'(gnt_idx)*2 +: 2];

  always_comb begin
    result = '0;
    unique case (opc)
      2'd0:    result = op_a + op_b;
      2'd1:    result = op_a;
      2'd2:    result = op_a - op_b;
      default: result = op_a ^ op_b;
    endcase
  end

`ifdef OP_SHARE_SCHED_CARRY_EN
  // A wrapped sum is smaller than either addend; borrow is simply A<B.
  always_comb begin
    carry_res = 1'b0;
    unique case (opc)
      2'd0:    carry_res = (result < op_a);
      2'd2:    carry_res = (op_a < op_b);
      default: carry_res = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
`ifdef OP_SHARE_SCHED_CARRY_EN
    carry_d = carry_q;
`endif
    if (transfer) begin
      state_d = FULL;
      data_d  = result;
      id_d    = gnt_idx;
      ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
`ifdef OP_SHARE_SCHED_CARRY_EN
      carry_d = carry_res;
`endif
    end else if ((state_q == FULL) && bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
`ifdef OP_SHARE_SCHED_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
`ifdef OP_SHARE_SCHED_CARRY_EN
      carry_q <= carry_d;
`endif
    end
  end
endmodule

// File: tb/tb_op_share_sched.sv
// Self-checking bench for op_share_sched (WIDTH=8, NREQ=3): directed steps plus
// randomized traffic against an integer-arithmetic reference of the scheduling rules.
module tb_op_share_sched;
  localparam int W = 8;
  localparam int N = 3;

  logic CLK;
  logic RST;

  op_share_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

  op_share_sched #(.WIDTH(W), .NREQ(N)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Stimulus held by the directed/random sequence.
  logic [N-1:0] vld;
  logic         rdy;
  int           a[N];
  int           b[N];
  int           op[N];

  // Reference model state.
  int m_ptr;
  bit m_full;
  int m_data;
  int m_id;
  int m_carry;
  int last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = vld;
    bus.rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = 8'(a[i]);
      bus.req_b[i*W +: W] = 8'(b[i]);
      bus.req_op[i*2 +: 2] = 2'(op[i]);
    end
  endtask

  task automatic set_req(input int i, input int av, input int bv, input int opv);
    a[i] = av;
    b[i] = bv;
    op[i] = opv;
  endtask

  // One clock: check the combinational grant, clock it, check the registered response.
  task automatic cycle(input string tag);
    int g;
    int x;
    int y;
    bit can;
    bit was_rst;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    can = !m_full || rdy;
    exp_rdy = (!RST && can && g >= 0) ? N'(1 << g) : '0;
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    was_rst = RST;
    @(posedge CLK);
    #1;
    last_g = -1;
    if (was_rst) begin
      m_full = 0; m_ptr = 0; m_data = 0; m_id = 0; m_carry = 0;
    end else if (exp_rdy != '0) begin
      x = a[g]; y = b[g];
      m_full = 1; m_id = g; m_ptr = (g + 1) % N; last_g = g;
      case (op[g])
        0: begin m_data = (x + y) % 256;       m_carry = (x + y > 255) ? 1 : 0; end
        1: begin m_data = x;                   m_carry = 0; end
        2: begin m_data = (x - y + 256) % 256; m_carry = (x < y) ? 1 : 0; end
        default: begin m_data = x ^ y;         m_carry = 0; end
      endcase
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(m_full));
    if (m_full || was_rst) begin
      chk({tag, ".rsp_data"}, 32'(bus.rsp_data), 32'(m_data));
      chk({tag, ".rsp_id"}, 32'(bus.rsp_id), 32'(m_id));
`ifdef OP_SHARE_SCHED_CARRY_EN
      chk({tag, ".rsp_carry"}, 32'(bus.rsp_carry), 32'(m_carry));
`endif
    end
  endtask

  initial begin
    logic [N-1:0] pend;
    m_ptr = 0; m_full = 0; m_data = 0; m_id = 0; m_carry = 0; last_g = -1;
    RST = 1'b1;
    rdy = 1'b1;
    vld = '1;
    set_req(0, 1, 2, 0);
    set_req(1, 10, 20, 0);
    set_req(2, 100, 100, 0);

    // Reset held two cycles with every requester valid.
    cycle("rst0");
    cycle("rst1");
    chk("rst.rsp_data", 32'(bus.rsp_data), 32'd0);

    // Round robin, all add, consumer always ready.
    RST = 1'b0;
    cycle("rr0"); chk("rr0.data", 32'(bus.rsp_data), 32'd3);   chk("rr0.id", 32'(bus.rsp_id), 32'd0);
    cycle("rr1"); chk("rr1.data", 32'(bus.rsp_data), 32'd30);  chk("rr1.id", 32'(bus.rsp_id), 32'd1);
    cycle("rr2"); chk("rr2.data", 32'(bus.rsp_data), 32'd200); chk("rr2.id", 32'(bus.rsp_id), 32'd2);
    cycle("rr3"); chk("rr3.data", 32'(bus.rsp_data), 32'd3);   chk("rr3.id", 32'(bus.rsp_id), 32'd0);

    // Wrap-around add and sub borrow on requester 1.
    vld = 3'b010;
    set_req(1, 200, 100, 0);
    cycle("wrap_add"); chk("wrap_add.data", 32'(bus.rsp_data), 32'd44);
    set_req(1, 5, 7, 2);
    cycle("sub_neg");  chk("sub_neg.data", 32'(bus.rsp_data), 32'd254);
`ifdef OP_SHARE_SCHED_CARRY_EN
    chk("sub_neg.carry", 32'(bus.rsp_carry), 32'd1);
`endif
    set_req(1, 10, 20, 0);

    // Backpressure: four stalled cycles, then release.
    vld = '1;
    cycle("bp_load"); chk("bp_load.id", 32'(bus.rsp_id), 32'd2);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("bp_hold");
      chk("bp_hold.data", 32'(bus.rsp_data), 32'd200);
      chk("bp_hold.id", 32'(bus.rsp_id), 32'd2);
    end
    rdy = 1'b1;
    drive();
    #1;
    chk("bp_release.grant", 32'(bus.req_ready), 32'b001);
    cycle("bp_release"); chk("bp_release.id", 32'(bus.rsp_id), 32'd0);

    // Sparse: lone r2, idle gap, then r0 and r1 together.
    vld = 3'b100;
    cycle("sparse_r2"); chk("sparse_r2.id", 32'(bus.rsp_id), 32'd2);
    vld = '0;
    for (int i = 0; i < 3; i++) cycle("idle");
    vld = 3'b011;
    cycle("pair0"); chk("pair0.id", 32'(bus.rsp_id), 32'd0);
    cycle("pair1"); chk("pair1.id", 32'(bus.rsp_id), 32'd1);

    // Reset while a result is stalled.
    vld = '1;
    cycle("mid_load");
    rdy = 1'b0;
    RST = 1'b1;
    cycle("mid_rst");
    RST = 1'b0;
    rdy = 1'b1;
    cycle("post_rst"); chk("post_rst.id", 32'(bus.rsp_id), 32'd0);

    // Randomized traffic; a pending request keeps its operands until granted.
    vld = '0;
    cycle("drain");
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1'b1;
          set_req(i, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                  int'($urandom_range(3, 0)));
        end
      end
      vld = pend;
      rdy = ($urandom_range(3, 0) != 0);
      cycle("rand");
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
